// File: rtl/zero_detect_sched.sv
// Round-robin scheduler sharing one serial zero-after-ones detector among N_REQ requesters.
// Each granted word is shifted MSB-first; the hit count is reported with a tagged done pulse.
module zero_detect_sched #(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int IW    = $clog2(N_REQ),
    parameter int CW    = $clog2(W + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] data,
    output logic [N_REQ-1:0]   gnt,
    output logic               busy,
    output logic               ser_x,
    output logic               ser_y,
    output logic               done,
    output logic [IW-1:0]      done_id,
    output logic [CW-1:0]      count
);

    localparam int BW = $clog2(W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic {NONE, ONES} det_t;

    state_t        state, state_nx;
    det_t          det;
    logic [IW-1:0] ptr, ptr_nx, win_idx, job_idx;
    logic [W-1:0]  sreg, win_word;
    logic [BW-1:0] bcnt;
    logic [CW-1:0] acc;
    logic          found, last_bit;
    logic [W-1:0]  words [N_REQ];
    logic [IW:0]   cand_wide;
    logic [IW-1:0] cand;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign words[g] = data[g*W +: W];
    end

    // Search starts at ptr and wraps modulo N_REQ; the first requester found wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves a latch.
        found     = 1'b0;
        win_idx   = '0;
        win_word  = '0;
        cand_wide = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_wide = {1'b0, ptr} + (IW+1)'(i);
            if (cand_wide >= (IW+1)'(N_REQ))
                cand_wide = cand_wide - (IW+1)'(N_REQ);
            cand = cand_wide[IW-1:0];
            if (!found && req[cand]) begin
                found    = 1'b1;
                win_idx  = cand;
                win_word = words[cand];
            end
        end
    end

    assign ptr_nx   = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
    assign last_bit = (bcnt == BW'(W - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = SHIFT;
            SHIFT:   if (last_bit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        done  = (state == DONE);
        ser_x = (state == SHIFT) && sreg[W-1];
        ser_y = (state == SHIFT) && (det == ONES) && !sreg[W-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr     <= '0;
            sreg    <= '0;
            bcnt    <= '0;
            acc     <= '0;
            det     <= NONE;
            gnt     <= '0;
            job_idx <= '0;
            done_id <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    sreg    <= win_word;
                    gnt     <= N_REQ'(1) << win_idx;
                    job_idx <= win_idx;
                    ptr     <= ptr_nx;
                    bcnt    <= '0;
                    acc     <= '0;
                    det     <= NONE;
                end
                SHIFT: begin
                    acc  <= acc + CW'(ser_y);
                    sreg <= {sreg[W-2:0], 1'b0};
                    bcnt <= bcnt + BW'(1);
                    det  <= ser_x ? ONES : NONE;
                    // Result registers load on the last bit so they are valid throughout DONE.
                    if (last_bit) begin
                        done_id <= job_idx;
                        count   <= acc + CW'(ser_y);
                    end
                end
                DONE:    gnt <= '0;
                default: gnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_zero_detect_sched.sv
// Self-checking bench for zero_detect_sched: directed scenarios plus randomized jobs
// compared against a word-level reference of the arbitration and hit counting.
module tb_zero_detect_sched;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] data = '0;
    logic [N-1:0]   gnt;
    logic           busy, ser_x, ser_y, done;
    logic [IW-1:0]  done_id;
    logic [CW-1:0]  count;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int model_ptr   = 0;

    zero_detect_sched #(.N_REQ(N), .W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt), .busy(busy),
        .ser_x(ser_x), .ser_y(ser_y), .done(done), .done_id(done_id), .count(count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // A hit is a 0 immediately following a 1 inside the same word, MSB first.
    function automatic int hits(input logic [W-1:0] w);
        int n = 0;
        for (int j = 1; j < W; j++)
            if (w[W-j] && !w[W-1-j]) n++;
        return n;
    endfunction

    function automatic logic hit_at(input logic [W-1:0] w, input int j);
        if (j == 0) return 1'b0;
        return w[W-j] && !w[W-1-j];
    endfunction

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int i = 0; i < N; i++)
            if (m[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic apply_reset();
        rst  = 1'b0;
        req  = '0;
        data = '0;
        repeat (2) @(negedge clk);
        model_ptr = 0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_done(input int limit, output int c, output bit ok, output bit bad);
        ok  = 1'b0;
        bad = 1'b0;
        c   = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if ($countones(gnt) > 1 || (!busy && gnt != '0)) bad = 1'b1;
            if (done) begin
                ok = 1'b1;
                c  = cyc;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({gnt, busy, ser_x, ser_y, done, done_id, count} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got gnt=%b busy=%b x=%b y=%b done=%b id=%0d cnt=%0d, expected all 0",
                     gnt, busy, ser_x, ser_y, done, done_id, count);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({gnt, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got gnt=%b busy=%b done=%b, expected 0", gnt, busy, done);
        end
    endtask

    // One job from a lone requester, checked bit by bit; drop_at >= W drops req during DONE.
    task automatic run_single(input int idx, input logic [W-1:0] w, input int drop_at);
        int exp, c0;
        logic [N-1:0] eg;
        data[idx*W +: W] = w;
        req = '0;
        req[idx] = 1'b1;
        exp = pick(req, model_ptr);
        model_ptr = (exp + 1) % N;
        eg = N'(1) << exp;
        @(posedge clk);
        @(negedge clk);
        c0 = cyc;
        for (int j = 0; j < W; j++) begin
            if (j == drop_at) req[idx] = 1'b0;
            if (j == 0) data[idx*W +: W] = ~w;
            vectors++;
            if (gnt !== eg || busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL shift_ctrl[%0d] bit %0d: got gnt=%b busy=%b done=%b, expected gnt=%b busy=1 done=0",
                         idx, j, gnt, busy, done, eg);
            end
            vectors++;
            if (ser_x !== w[W-1-j] || ser_y !== hit_at(w, j)) begin
                miscompares++;
                $display("FAIL serial[%0d] word %h bit %0d: got x=%b y=%b, expected x=%b y=%b",
                         idx, w, j, ser_x, ser_y, w[W-1-j], hit_at(w, j));
            end
            @(negedge clk);
        end
        req[idx] = 1'b0;
        vectors++;
        if (done !== 1'b1 || int'(done_id) !== exp || int'(count) !== hits(w) || gnt !== eg || cyc - c0 !== W) begin
            miscompares++;
            $display("FAIL done_report[%0d] word %h: got done=%b id=%0d cnt=%0d gnt=%b lat=%0d, expected 1 %0d %0d %b %0d",
                     idx, w, done, done_id, count, gnt, cyc - c0, exp, hits(w), eg, W);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || gnt !== '0 || ser_x !== 1'b0 || ser_y !== 1'b0
            || int'(count) !== hits(w) || int'(done_id) !== exp) begin
            miscompares++;
            $display("FAIL after_done[%0d]: got done=%b busy=%b gnt=%b x=%b y=%b cnt=%0d id=%0d, expected idle, cnt=%0d id=%0d",
                     idx, done, busy, gnt, ser_x, ser_y, count, done_id, hits(w), exp);
        end
    endtask

    task automatic test_single();
        run_single(0, 8'b1011_0010, W);
    endtask

    task automatic test_patterns();
        run_single(0, 8'hFF, W);
        run_single(0, 8'h00, W);
        run_single(0, 8'hAA, W);
        run_single(0, 8'h55, W);
        run_single(0, 8'h01, W);
        run_single(0, 8'h00, W);
    endtask

    task automatic test_withdrawal();
        run_single(2, W'($urandom), 2);
    endtask

    task automatic test_round_robin();
        logic [W-1:0] w [N];
        int exp, c, prev;
        bit ok, bad;
        apply_reset();
        for (int i = 0; i < N; i++) begin
            w[i] = W'($urandom);
            data[i*W +: W] = w[i];
        end
        req  = '1;
        prev = 0;
        for (int n = 0; n < 5; n++) begin
            exp = pick(req, model_ptr);
            model_ptr = (exp + 1) % N;
            wait_done(3 * (W + 2), c, ok, bad);
            vectors++;
            if (!ok || bad || int'(done_id) !== exp || int'(count) !== hits(w[exp]) || gnt !== (N'(1) << exp)) begin
                miscompares++;
                $display("FAIL rr_job %0d: got ok=%b onehot_bad=%b id=%0d cnt=%0d gnt=%b, expected id=%0d cnt=%0d",
                         n, ok, bad, done_id, count, gnt, exp, hits(w[exp]));
            end
            if (n > 0) begin
                vectors++;
                if (c - prev !== W + 2) begin
                    miscompares++;
                    $display("FAIL rr_spacing %0d: got %0d cycles, expected %0d", n, c - prev, W + 2);
                end
            end
            prev = c;
            if (n == 4) req = '0;
        end
        @(negedge clk);
        vectors++;
        if (gnt !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_idle: got gnt=%b busy=%b, expected 0", gnt, busy);
        end
    endtask

    task automatic test_pointer();
        logic [W-1:0] w1, w3;
        int exp, c;
        bit ok, bad;
        run_single(2, W'($urandom), W);
        w1 = W'($urandom);
        w3 = W'($urandom);
        data[1*W +: W] = w1;
        data[3*W +: W] = w3;
        req = 4'b1010;
        for (int n = 0; n < 2; n++) begin
            exp = pick(req, model_ptr);
            model_ptr = (exp + 1) % N;
            wait_done(3 * (W + 2), c, ok, bad);
            vectors++;
            if (!ok || bad || int'(done_id) !== exp || int'(count) !== hits(exp == 3 ? w3 : w1)) begin
                miscompares++;
                $display("FAIL pointer_order %0d: got ok=%b bad=%b id=%0d cnt=%0d, expected id=%0d cnt=%0d",
                         n, ok, bad, done_id, count, exp, hits(exp == 3 ? w3 : w1));
            end
            req[exp] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_job();
        logic [W-1:0] w0;
        int exp, c;
        bit ok, bad;
        data[1*W +: W] = 8'hFF;
        req = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        repeat (4) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        vectors++;
        if ({gnt, busy, ser_x, ser_y, done, done_id, count} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_job: got gnt=%b busy=%b x=%b done=%b id=%0d cnt=%0d, expected all 0",
                     gnt, busy, ser_x, done, done_id, count);
        end
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_ptr = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || gnt !== '0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL no_done_after_reset %0d: got done=%b gnt=%b busy=%b, expected 0", i, done, gnt, busy);
            end
        end
        w0 = W'($urandom);
        data[0*W +: W] = w0;
        data[3*W +: W] = W'($urandom);
        req = 4'b1001;
        exp = pick(req, model_ptr);
        model_ptr = (exp + 1) % N;
        wait_done(3 * (W + 2), c, ok, bad);
        vectors++;
        if (!ok || bad || int'(done_id) !== exp || int'(count) !== hits(w0)) begin
            miscompares++;
            $display("FAIL post_reset_priority: got ok=%b id=%0d cnt=%0d, expected id=%0d cnt=%0d",
                     ok, done_id, count, exp, hits(w0));
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] w [N];
        logic [N-1:0] m;
        int exp, c;
        bit ok, bad;
        for (int it = 0; it < 24; it++) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                w[i] = W'($urandom);
                data[i*W +: W] = w[i];
            end
            req = m;
            exp = pick(m, model_ptr);
            model_ptr = (exp + 1) % N;
            wait_done(3 * (W + 2), c, ok, bad);
            vectors++;
            if (!ok || bad || int'(done_id) !== exp || int'(count) !== hits(w[exp]) || gnt !== (N'(1) << exp)) begin
                miscompares++;
                $display("FAIL random %0d mask %b: got ok=%b bad=%b id=%0d cnt=%0d gnt=%b, expected id=%0d cnt=%0d",
                         it, m, ok, bad, done_id, count, gnt, exp, hits(w[exp]));
            end
            req = '0;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_patterns();
        test_withdrawal();
        test_round_robin();
        test_pointer();
        test_reset_mid_job();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/zero_detect_sched.md
# zero_detect_sched

Round-robin scheduler that shares one serial zero-after-ones detector among `N_REQ` requesters. Each requester presents a `W`-bit word and holds `req`. The block grants one requester at a time and shifts the word MSB-first through its internal detector. It counts detector hits and returns the count with a one-cycle `done` pulse tagged with the requester index. It sits between the lab's parallel word sources and the serial detector datapath, turning a single-stream detector into a shared, job-based resource.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, range 2..8.
- `W`, default 8: word width in bits, range 2..16.
- `IW`, default `$clog2(N_REQ)`: width of the index field.
- `CW`, default `$clog2(W+1)`: width of the count field.

Ports:
- `clk`, input, 1 bit: clock, rising-edge.
- `rst`, input, 1 bit: reset, asynchronous, active-low.
- `req`, input, `N_REQ` bits: per-requester job request, level.
- `data`, input, `N_REQ*W` bits: requester i's word is `data[i*W +: W]`.
- `gnt`, output, `N_REQ` bits: one-hot grant, high for the whole job.
- `busy`, output, 1 bit: job in progress (SHIFT or DONE).
- `ser_x`, output, 1 bit: bit currently presented to the detector.
- `ser_y`, output, 1 bit: detector hit for the current bit.
- `done`, output, 1 bit: one-cycle pulse at end of job.
- `done_id`, output, `IW` bits: index of the requester whose job finished.
- `count`, output, `CW` bits: number of hits in the finished word.

## Operation
- **Controller states:** IDLE, SHIFT, DONE.
  - IDLE → SHIFT when `req != 0`.
  - SHIFT → DONE after W bits.
  - DONE → IDLE unconditionally.
- **Arbitration (IDLE only):** round-robin search starting at `ptr`, wrapping modulo N_REQ.
  - On reset, `ptr = 0`, so index 0 has highest priority.
  - On grant of index k, `ptr` becomes (k+1) mod N_REQ.
- **Job latch:** on the IDLE→SHIFT edge, the winner's word is copied into the shift register. `gnt[k]` is set, the bit counter is cleared, the hit accumulator is cleared, and the detector state is cleared.
- **Data stability:** `data` and `req` are ignored after the latch. If the requester drops `req` mid-job, the job still completes and is reported.
- **Detector:** two states.
  - States: NONE (no 1 since the last 0 or job start) and ONES (one or more consecutive 1s seen).
  - NONE goes to ONES on x=1 and stays NONE on x=0.
  - ONES stays ONES on x=1 and goes to NONE on x=0.
  - Mealy output: `ser_y = (det==ONES) && !ser_x`.
- **SHIFT:** `ser_x` is the shift-register MSB.
  - Each cycle, the accumulator adds `ser_y`, the register shifts left by one, and the bit counter increments.
  - After the bit with counter W-1, the next state is DONE.
- **DONE:** `done`=1, `done_id`=k, `count`=final accumulator, and `gnt` is still held.
  - `gnt` clears on leaving DONE.
  - `done_id` and `count` hold their values until the next DONE.
- **Outside SHIFT:** `ser_x`=0 and `ser_y`=0.
- **Count range:** the maximum count is floor(W/2), so it never overflows `CW`.

## Timing
- **Reset values:** all outputs 0.
  - Internal: state=IDLE, det=NONE, `ptr`=0, shift register, counters and accumulator 0.
- **Reset mid-job:** the job is abandoned. No `done` is issued and `gnt` drops immediately (asynchronously).
- **Latency:** if `req` is sampled high at edge t, then:
  - `gnt` and the first bit are valid after edge t.
  - Bit j is presented in cycle t+1+j.
  - `done` is high in cycle t+W+1.
- **Throughput:** with continuous requests, one job per W+2 cycles (SHIFT W, DONE 1, IDLE 1).
- **Simultaneous requests:** only one grant per arbitration. Losers keep `req` high and are served in later rounds. No requester waits more than N_REQ-1 jobs.
- **Re-request:** `req` still high during DONE makes that requester eligible again in IDLE, subject to `ptr`. The requester must drop `req` on `done` if it wants a single job.
- **Grant encoding:** `gnt` never has more than one bit set, and is 0 in IDLE.

## Test plan
- **Single word, mixed bits:** requester 0 `req` with word 8'b1011_0010. Expect `ser_y` high on bits 1, 4 and 7; `done` 9 cycles after `req` is sampled; `done_id`=0; `count`=3.
- **Pattern words:** 8'hFF → `count`=0. 8'h00 → 0. 8'hAA → 4. 8'h55 → 3. The detector must not carry state between jobs (8'h01 followed by 8'h00 gives 0, then 0).
- **Round-robin rotation:** all four `req` held high. Expect grants in order 0, 1, 2, 3, 0, with jobs spaced 10 cycles apart and `gnt` always one-hot.
- **Pointer behaviour:** after a grant to index 2, raise `req` on 1 and 3 together. Expect 3 to be granted before 1.
- **Request withdrawal:** drop `req` in the third SHIFT cycle. The job completes and `done`/`count` are still reported for that index.
- **Reset mid-job:** assert `rst` low at bit 4. All outputs go to 0 immediately with no `done`. After release, a new request is served from index 0 priority.
